lcd_drive: RTL and testbench
============================

Name: lcd_drive

Overview:
- Consumer end of the host-written LCD register on the ACW.
- Takes the latched MO and DOEN levels plus a host byte stream written into a small FIFO.
- Serialises the bytes as 4-bit nibbles to an external dot-matrix LCD panel, generating shift clock, line latch, first-line marker and AC-drive signals.
- Sits beside the status block in SLIPSTREAM and drives the panel pins directly.

Parameters:
- LINE_BYTES, 40: bytes per display line (2×LINE_BYTES nibbles shifted per line).
- LINES, 200: lines per frame.
- DIV, 4: CLK cycles per nibble period and per LP pulse; even, ≥2.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RESET_0  in  1  asynchronous active-high reset.
- WD  in  8  host write data.
- LCDW  in  1  one-cycle strobe: push WD into the FIFO.
- MO  in  1  AC mode: 0 = M toggles per frame, 1 = M toggles per line.
- DOEN  in  1  display enable level.
- LD  out  4  panel nibble data.
- XSCL  out  1  panel shift clock.
- LP  out  1  line latch pulse.
- FLM  out  1  first-line marker.
- M  out  1  LCD AC drive.
- DISPOFFL  out  1  panel display-off, active low (= registered DOEN).
- FULL  out  1  FIFO full.
- UNDER  out  1  sticky underrun flag.
- OVER  out  1  sticky overrun flag.

Behaviour:
- Reset: all outputs 0. FIFO empty, state IDLE, phase 0, nibble 0, line 0, nibble select high.
- FIFO:
  - 4 entries × 8 bits.
  - LCDW with FULL=0 pushes WD.
  - LCDW with FULL=1 drops WD and sets OVER, even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle are both honoured when not full.
  - FULL is registered; it reflects occupancy 4 in the cycle after the push.
- Nibble order: high nibble of each byte first, then low nibble. The byte is popped when its low nibble is loaded.
- Phase counter: 0..DIV-1, wraps; it runs only in SHIFT and LATCH.
- IDLE:
  - LD=0, XSCL=0, LP=0.
  - Go to SHIFT when DOEN=1 and the FIFO is non-empty; phase=0.
- SHIFT:
  - At phase 0, load the next nibble to LD.
  - XSCL=1 for phases DIV/2..DIV-1 (falling edge at wrap).
  - After the final nibble (index 2×LINE_BYTES-1) completes phase DIV-1, go to LATCH.
  - If the FIFO is empty when a high nibble is due at phase 0: hold phase 0, XSCL=0, LD unchanged, set UNDER. Resume on the first cycle the FIFO is non-empty.
- LATCH:
  - LP=1 for exactly DIV cycles; LD=0, XSCL=0.
  - FLM=1 for the same DIV cycles when the line just finished is LINES-1.
  - At the end of LP: line increments, wrapping LINES-1→0; nibble index resets to 0; go to SHIFT.
  - M toggles at the end of LP when MO=1, or when MO=0 and the line wrapped to 0.
- DOEN:
  - DOEN is registered once to DISPOFFL.
  - On registered DOEN=0, from any state, in the next cycle: go to IDLE, flush the FIFO, line=0, nibble=0, LD/XSCL/LP/FLM=0, clear UNDER and OVER. M holds its value.
  - LCDW writes while DOEN=0 are dropped without setting OVER.
- MO may change at any time; it is sampled at each LP end.
- Reset mid-line aborts immediately to reset values.

Test Plan:
- Shift order: LINE_BYTES=2, LINES=3, DIV=4. Reset, DOEN=1, write A5,3C. → LD sequence A,5,3,C, each held 4 cycles; 4 XSCL pulses, each high 2 cycles; then LP high 4 cycles; FLM=0; line=1.
- Frame wrap: continue the 2×2 bytes/line for 3 lines with MO=0. → FLM=1 only during the third LP; M 0→1 at its end; line back to 0.
- Per-line AC: MO=1, run 3 lines. → M toggles at every LP end (1,0,1).
- FIFO edges: with DOEN=1 and the engine stalled, write 5 bytes back-to-back. → FULL=1 after the 4th; 5th dropped, OVER=1. After underrun (FIFO drained mid-line): XSCL stops, UNDER=1; a new write resumes at the next high nibble.
- Disable mid-line: drop DOEN during the 2nd nibble. → after 2 cycles DISPOFFL=0, state IDLE, FIFO empty, UNDER/OVER=0. Re-enabling and writing restarts at line 0, nibble 0.
- Async reset: assert RESET_0 mid-LATCH. → LP, FLM, M, FULL and all other outputs 0 without waiting for a CLK edge.

Source files
------------

// File: rtl/lcd_drive.sv
//------------------------------------------------------------------------------
// lcd_drive : FIFO-fed 4-bit nibble serialiser for a dot-matrix LCD panel.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_drive #(
    parameter int LINE_BYTES = 40,
    parameter int LINES      = 200,
    parameter int DIV        = 4
) (
    input  logic       CLK,
    input  logic       RESET_0,
    input  logic [7:0] WD,
    input  logic       LCDW,
    input  logic       MO,
    input  logic       DOEN,
    output logic [3:0] LD,
    output logic       XSCL,
    output logic       LP,
    output logic       FLM,
    output logic       M,
    output logic       DISPOFFL,
    output logic       FULL,
    output logic       UNDER,
    output logic       OVER
);

    localparam int NIBS = 2 * LINE_BYTES;
    localparam int NW   = (NIBS  > 1) ? $clog2(NIBS)  : 1;
    localparam int LW   = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int PW   = (DIV   > 1) ? $clog2(DIV)   : 1;

    localparam logic [PW-1:0] c_PH_LAST  = PW'(DIV - 1);
    localparam logic [PW-1:0] c_PH_HALF  = PW'(DIV / 2);
    localparam logic [NW-1:0] c_NIB_LAST = NW'(NIBS - 1);
    localparam logic [LW-1:0] c_LN_LAST  = LW'(LINES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_STALL = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t        state_q;
    logic [PW-1:0] phase_q;
    logic [NW-1:0] nib_q;
    logic [LW-1:0] line_q;
    logic [3:0]    ld_q;
    logic          xscl_q;
    logic          lp_q;
    logic          flm_q;
    logic          m_q;
    logic          under_q;
    logic          doen_q;

    logic [7:0]    mem_q [4];
    logic [1:0]    wr_q;
    logic [1:0]    rd_q;
    logic [2:0]    cnt_q;
    logic [2:0]    cnt_d;
    logic          full_q;
    logic          over_q;

    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [7:0]    w_head;
    logic [PW-1:0] w_phase_n;

    assign w_empty   = (cnt_q == 3'd0);
    assign w_head    = mem_q[rd_q];
    assign w_phase_n = phase_q + 1'b1;
    assign w_push    = LCDW && doen_q && !full_q;
    // The byte leaves the FIFO as its low nibble is loaded at the end of the high-nibble period.
    assign w_pop     = doen_q && (state_q == S_SHIFT) && (phase_q == c_PH_LAST) && !nib_q[0];
    assign cnt_d     = cnt_q + {2'b00, w_push} - {2'b00, w_pop};

    always_ff @(posedge CLK) begin
        if (w_push) begin
            mem_q[wr_q] <= WD;
        end
    end

    always_ff @(posedge CLK or posedge RESET_0) begin
        if (RESET_0) begin
            wr_q   <= 2'd0;
            rd_q   <= 2'd0;
            cnt_q  <= 3'd0;
            full_q <= 1'b0;
            over_q <= 1'b0;
        end else if (!doen_q) begin
            wr_q   <= 2'd0;
            rd_q   <= 2'd0;
            cnt_q  <= 3'd0;
            full_q <= 1'b0;
            over_q <= 1'b0;
        end else begin
            if (w_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (w_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == 3'd4);
            if (LCDW && full_q) begin
                over_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET_0) begin
        if (RESET_0) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            nib_q   <= '0;
            line_q  <= '0;
            ld_q    <= 4'd0;
            xscl_q  <= 1'b0;
            lp_q    <= 1'b0;
            flm_q   <= 1'b0;
            m_q     <= 1'b0;
            under_q <= 1'b0;
            doen_q  <= 1'b0;
        end else begin
            doen_q <= DOEN;
            if (!doen_q) begin
                // Display disabled: everything returns to the start of a frame except M.
                state_q <= S_IDLE;
                phase_q <= '0;
                nib_q   <= '0;
                line_q  <= '0;
                ld_q    <= 4'd0;
                xscl_q  <= 1'b0;
                lp_q    <= 1'b0;
                flm_q   <= 1'b0;
                under_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (!w_empty) begin
                            state_q <= S_SHIFT;
                            phase_q <= '0;
                            ld_q    <= w_head[7:4];
                            xscl_q  <= 1'b0;
                        end
                    end

                    S_SHIFT: begin
                        if (phase_q == c_PH_LAST) begin
                            phase_q <= '0;
                            xscl_q  <= 1'b0;
                            if (nib_q == c_NIB_LAST) begin
                                state_q <= S_LATCH;
                                ld_q    <= 4'd0;
                                lp_q    <= 1'b1;
                                flm_q   <= (line_q == c_LN_LAST);
                            end else if (!nib_q[0]) begin
                                nib_q <= nib_q + 1'b1;
                                ld_q  <= w_head[3:0];
                            end else begin
                                nib_q <= nib_q + 1'b1;
                                if (!w_empty) begin
                                    ld_q <= w_head[7:4];
                                end else begin
                                    state_q <= S_STALL;
                                    under_q <= 1'b1;
                                end
                            end
                        end else begin
                            phase_q <= w_phase_n;
                            xscl_q  <= (w_phase_n >= c_PH_HALF);
                        end
                    end

                    S_STALL: begin
                        if (!w_empty) begin
                            state_q <= S_SHIFT;
                            ld_q    <= w_head[7:4];
                        end
                    end

                    S_LATCH: begin
                        if (phase_q == c_PH_LAST) begin
                            phase_q <= '0;
                            nib_q   <= '0;
                            lp_q    <= 1'b0;
                            flm_q   <= 1'b0;
                            line_q  <= (line_q == c_LN_LAST) ? '0 : line_q + 1'b1;
                            if (MO || (line_q == c_LN_LAST)) begin
                                m_q <= !m_q;
                            end
                            if (!w_empty) begin
                                state_q <= S_SHIFT;
                                ld_q    <= w_head[7:4];
                            end else begin
                                state_q <= S_STALL;
                                under_q <= 1'b1;
                            end
                        end else begin
                            phase_q <= w_phase_n;
                        end
                    end

                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign LD       = ld_q;
    assign XSCL     = xscl_q;
    assign LP       = lp_q;
    assign FLM      = flm_q;
    assign M        = m_q;
    assign DISPOFFL = doen_q;
    assign FULL     = full_q;
    assign UNDER    = under_q;
    assign OVER     = over_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_drive.sv
//------------------------------------------------------------------------------
// tb_lcd_drive : directed self-checking bench for lcd_drive (2 bytes/line, 3 lines).
// Revision     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lcd_drive;

    logic       CLK;
    logic       RESET_0;
    logic [7:0] WD;
    logic       LCDW;
    logic       MO;
    logic       DOEN;
    logic [3:0] LD;
    logic       XSCL;
    logic       LP;
    logic       FLM;
    logic       M;
    logic       DISPOFFL;
    logic       FULL;
    logic       UNDER;
    logic       OVER;

    int checks = 0;
    int errors = 0;

    lcd_drive #(
        .LINE_BYTES(2),
        .LINES     (3),
        .DIV       (4)
    ) dut (
        .CLK     (CLK),
        .RESET_0 (RESET_0),
        .WD      (WD),
        .LCDW    (LCDW),
        .MO      (MO),
        .DOEN    (DOEN),
        .LD      (LD),
        .XSCL    (XSCL),
        .LP      (LP),
        .FLM     (FLM),
        .M       (M),
        .DISPOFFL(DISPOFFL),
        .FULL    (FULL),
        .UNDER   (UNDER),
        .OVER    (OVER)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200us;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        RESET_0 = 1'b1;
        repeat (2) @(negedge CLK);
        RESET_0 = 1'b0;
        @(negedge CLK);
    endtask

    task automatic wr_byte(input logic [7:0] b);
        WD   = b;
        LCDW = 1'b1;
        @(negedge CLK);
        LCDW = 1'b0;
    endtask

    // Feed one full line and compare every cycle from the first nibble through the LP pulse.
    task automatic run_line(input logic [7:0] b0, input logic [7:0] b1,
                            input logic flm_exp, input logic m_exp);
        logic [3:0] nib [4];
        logic [6:0] exp_v;
        logic       found;
        nib[0] = b0[7:4];
        nib[1] = b0[3:0];
        nib[2] = b1[7:4];
        nib[3] = b1[3:0];
        wr_byte(b0);
        wr_byte(b1);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (LD != 4'd0) begin
                found = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        check("line_start", found, 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (k < 16) exp_v = {nib[k/4], ((k % 4) >= 2), 1'b0, 1'b0};
            else        exp_v = {4'd0, 1'b0, 1'b1, flm_exp};
            check($sformatf("line_cyc%0d", k), {LD, XSCL, LP, FLM}, exp_v);
            @(negedge CLK);
        end
        check("lp_end", LP, 1'b0);
        check("m_after_lp", M, m_exp);
    endtask

    task automatic wait_lp(output logic found);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (LP) begin
                found = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        logic       found;
        logic [7:0] fifo_bytes [5];
        fifo_bytes[0] = 8'h11;
        fifo_bytes[1] = 8'h22;
        fifo_bytes[2] = 8'h33;
        fifo_bytes[3] = 8'h44;
        fifo_bytes[4] = 8'h55;

        RESET_0 = 1'b1;
        WD      = 8'h00;
        LCDW    = 1'b0;
        MO      = 1'b0;
        DOEN    = 1'b0;
        @(negedge CLK);
        check("reset_in", {LD, XSCL, LP, FLM, M, DISPOFFL, FULL, UNDER, OVER}, 12'h000);
        @(negedge CLK);
        RESET_0 = 1'b0;
        @(negedge CLK);
        check("reset_out", {LD, XSCL, LP, FLM, M, DISPOFFL, FULL, UNDER, OVER}, 12'h000);

        // Shift order and frame wrap with per-frame AC drive.
        DOEN = 1'b1;
        repeat (3) @(negedge CLK);
        check("dispoffl_on", DISPOFFL, 1'b1);
        check("under_clear", UNDER, 1'b0);
        run_line(8'hA5, 8'h3C, 1'b0, 1'b0);
        check("under_line_start", UNDER, 1'b1);
        run_line(8'h96, 8'hE1, 1'b0, 1'b0);
        run_line(8'hF0, 8'h87, 1'b1, 1'b1);

        // Mid-line underrun: one byte only, then resume with the second.
        wr_byte(8'h5A);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (LD != 4'd0) begin
                found = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        check("ur_start", found, 1'b1);
        check("ur_hi", LD, 4'h5);
        repeat (12) @(negedge CLK);
        check("ur_hold_ld", LD, 4'hA);
        check("ur_xscl0", XSCL, 1'b0);
        @(negedge CLK);
        check("ur_xscl1", XSCL, 1'b0);
        check("ur_flag", UNDER, 1'b1);
        wr_byte(8'h2B);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (LD == 4'h2) begin
                found = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        check("ur_resume", found, 1'b1);
        repeat (4) @(negedge CLK);
        check("ur_resume_lo", LD, 4'hB);
        wait_lp(found);
        check("ur_lp", found, 1'b1);
        repeat (5) @(negedge CLK);
        check("ur_m_hold", M, 1'b1);

        // Per-line AC drive from a fresh reset.
        do_reset();
        check("reset2_m", M, 1'b0);
        DOEN = 1'b1;
        MO   = 1'b1;
        repeat (3) @(negedge CLK);
        run_line(8'hC3, 8'h1D, 1'b0, 1'b1);
        run_line(8'h4E, 8'h77, 1'b0, 1'b0);
        run_line(8'hB2, 8'h68, 1'b1, 1'b1);

        // FIFO full / overrun: five back-to-back writes.
        LCDW = 1'b1;
        for (int i = 0; i < 5; i++) begin
            WD = fifo_bytes[i];
            @(negedge CLK);
            if (i == 2) check("fifo_not_full", FULL, 1'b0);
            if (i == 3) check("fifo_full", FULL, 1'b1);
        end
        LCDW = 1'b0;
        check("fifo_over", OVER, 1'b1);
        repeat (50) @(negedge CLK);
        check("fifo_drained", {LD, XSCL, LP, FULL}, 7'h00);
        check("fifo_under", UNDER, 1'b1);
        check("fifo_over_sticky", OVER, 1'b1);
        check("fifo_m", M, 1'b1);

        // Disable mid-line during the second nibble.
        wr_byte(8'hA5);
        wr_byte(8'h3C);
        repeat (4) @(negedge CLK);
        check("dis_nib2", LD, 4'h5);
        DOEN = 1'b0;
        repeat (2) @(negedge CLK);
        check("dis_dispoffl", DISPOFFL, 1'b0);
        check("dis_outs", {LD, XSCL, LP, FLM, FULL, UNDER, OVER}, 10'h000);
        check("dis_m_hold", M, 1'b1);
        LCDW = 1'b1;
        WD   = 8'h77;
        repeat (5) @(negedge CLK);
        LCDW = 1'b0;
        check("dis_wr_drop", {FULL, OVER}, 2'b00);
        DOEN = 1'b1;
        MO   = 1'b0;
        repeat (6) @(negedge CLK);
        check("dis_flushed", LD, 4'h0);
        run_line(8'hA5, 8'h3C, 1'b0, 1'b1);
        run_line(8'h96, 8'hE1, 1'b0, 1'b1);
        wr_byte(8'hF0);
        wr_byte(8'h87);
        wait_lp(found);
        check("last_lp", found, 1'b1);
        check("last_flm", FLM, 1'b1);

        // Asynchronous reset in the middle of LATCH.
        #1;
        RESET_0 = 1'b1;
        #1;
        check("async_rst", {LD, XSCL, LP, FLM, M, DISPOFFL, FULL, UNDER, OVER}, 12'h000);
        @(negedge CLK);
        RESET_0 = 1'b0;
        @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
